// File: rtl/fp_wb_pkg.sv
// rtl/fp_wb_pkg.sv - shared widths and entry layout for the FP add/sub writeback stage
package fp_wb_pkg;

    localparam int FP_DATA_WIDTH = 64;
    localparam int FP_TAG_WIDTH  = 5;

    // Entry layout, MSB to LSB: {OF, UF, tag, result}
    localparam int ENT_RES_LSB    = 0;
    localparam int ENT_TAG_LSB    = FP_DATA_WIDTH;
    localparam int ENT_UF_BIT     = FP_DATA_WIDTH + FP_TAG_WIDTH;
    localparam int ENT_OF_BIT     = FP_DATA_WIDTH + FP_TAG_WIDTH + 1;
    localparam int FP_ENTRY_WIDTH = FP_DATA_WIDTH + FP_TAG_WIDTH + 2;

    function automatic int entry_width(input int dw, input int tw);
        return dw + tw + 2;
    endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// rtl/fp_wb_fifo.sv - synchronous FIFO buffering writeback entries
module fp_wb_fifo
    import fp_wb_pkg::*;
#(
    parameter int WIDTH = FP_ENTRY_WIDTH,
    parameter int DEPTH = 2
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_i && !pop_i)      count_d = count_q + 1'b1;
        else if (!push_i && pop_i) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fp_addsub_wb.sv
// rtl/fp_addsub_wb.sv - FP add/sub writeback: buffered register-file writes, sticky flags, commit count, irq
module fp_addsub_wb
    import fp_wb_pkg::*;
#(
    parameter int DATA_WIDTH = FP_DATA_WIDTH,
    parameter int TAG_WIDTH  = FP_TAG_WIDTH,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = 16
)
(
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_valid,
    output logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  in_flag_OF,
    input  logic                  in_flag_UF,
    input  logic [TAG_WIDTH-1:0]  in_rd,
    output logic                  out_wr_en,
    input  logic                  in_wr_ready,
    output logic [TAG_WIDTH-1:0]  out_wr_addr,
    output logic [DATA_WIDTH-1:0] out_wr_data,
    input  logic                  in_flag_clr,
    input  logic                  in_irq_en,
    output logic                  out_sticky_OF,
    output logic                  out_sticky_UF,
    output logic                  out_irq,
    output logic [CNT_WIDTH-1:0]  out_commit_cnt
);

    localparam int EW = entry_width(DATA_WIDTH, TAG_WIDTH);

    logic          full, empty, push, pop;
    logic [EW-1:0] wdata, head;
    logic          head_of, head_uf;

    logic                 sticky_of_q, sticky_of_d;
    logic                 sticky_uf_q, sticky_uf_d;
    logic                 irq_q, irq_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // No bypass: readiness is purely a function of occupancy
    assign out_ready = ~full;
    assign out_wr_en = ~empty;
    assign push      = in_valid & out_ready;
    assign pop       = out_wr_en & in_wr_ready;

    assign wdata       = {in_flag_OF, in_flag_UF, in_rd, in_result};
    assign out_wr_data = head[DATA_WIDTH-1:0];
    assign out_wr_addr = head[DATA_WIDTH +: TAG_WIDTH];
    assign head_uf     = head[EW-2];
    assign head_of     = head[EW-1];

    fp_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (in_clk),
        .rst_i   (in_rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // Clear is applied before the committing flags are merged so a new event survives
    always_comb begin
        sticky_of_d = in_flag_clr ? 1'b0 : sticky_of_q;
        sticky_uf_d = in_flag_clr ? 1'b0 : sticky_uf_q;
        cnt_d       = cnt_q;
        irq_d       = pop & head_of & in_irq_en;
        if (pop) begin
            sticky_of_d = sticky_of_d | head_of;
            sticky_uf_d = sticky_uf_d | head_uf;
            cnt_d       = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            sticky_of_q <= 1'b0;
            sticky_uf_q <= 1'b0;
            irq_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sticky_of_q <= sticky_of_d;
            sticky_uf_q <= sticky_uf_d;
            irq_q       <= irq_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_sticky_OF  = sticky_of_q;
    assign out_sticky_UF  = sticky_uf_q;
    assign out_irq        = irq_q;
    assign out_commit_cnt = cnt_q;

endmodule

// File: tb/tb_fp_addsub_wb.sv
// tb/tb_fp_addsub_wb.sv - directed self-checking bench for fp_addsub_wb
module tb_fp_addsub_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_result;
    logic        in_flag_OF, in_flag_UF;
    logic [4:0]  in_rd;
    logic        out_wr_en;
    logic        in_wr_ready;
    logic [4:0]  out_wr_addr;
    logic [63:0] out_wr_data;
    logic        in_flag_clr, in_irq_en;
    logic        out_sticky_OF, out_sticky_UF, out_irq;
    logic [15:0] out_commit_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] q_data [$];
    logic [4:0]  q_addr [$];
    int          n_wr;
    logic        ready_drop;

    always #5 clk = ~clk;

    fp_addsub_wb dut (
        .in_clk         (clk),
        .in_rst         (rst),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
        .in_result      (in_result),
        .in_flag_OF     (in_flag_OF),
        .in_flag_UF     (in_flag_UF),
        .in_rd          (in_rd),
        .out_wr_en      (out_wr_en),
        .in_wr_ready    (in_wr_ready),
        .out_wr_addr    (out_wr_addr),
        .out_wr_data    (out_wr_data),
        .in_flag_clr    (in_flag_clr),
        .in_irq_en      (in_irq_en),
        .out_sticky_OF  (out_sticky_OF),
        .out_sticky_UF  (out_sticky_UF),
        .out_irq        (out_irq),
        .out_commit_cnt (out_commit_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard step for the streaming phase, evaluated between edges
    task automatic observe();
        if (!out_ready) ready_drop = 1'b1;
        if (out_wr_en && in_wr_ready) begin
            if (q_data.size() == 0) begin
                chk("stream_unexpected_write", 64'd1, 64'd0);
            end else begin
                chk("stream_data", out_wr_data, q_data.pop_front());
                chk("stream_addr", 64'(out_wr_addr), 64'(q_addr.pop_front()));
            end
            n_wr++;
        end
        if (in_valid && out_ready) begin
            q_data.push_back(in_result);
            q_addr.push_back(in_rd);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_result = 64'hDEAD_BEEF_0000_0001;
        in_flag_OF = 1'b1; in_flag_UF = 1'b1; in_rd = 5'd9;
        in_wr_ready = 1'b1; in_flag_clr = 1'b0; in_irq_en = 1'b1;

        // Reset held with valid asserted
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_wr_en", 64'(out_wr_en), 64'd0);
            chk("rst_ready", 64'(out_ready), 64'd1);
            chk("rst_sticky", 64'({out_sticky_OF, out_sticky_UF}), 64'd0);
            chk("rst_cnt", 64'(out_commit_cnt), 64'd0);
            chk("rst_irq", 64'(out_irq), 64'd0);
        end
        rst = 1'b0; in_valid = 1'b0; in_flag_OF = 1'b0; in_flag_UF = 1'b0;
        tick();
        chk("idle_wr_en", 64'(out_wr_en), 64'd0);

        // Single op
        in_valid = 1'b1; in_result = 64'h3FF0_0000_0000_0000; in_rd = 5'd3;
        tick();
        in_valid = 1'b0;
        chk("single_wr_en", 64'(out_wr_en), 64'd1);
        chk("single_addr", 64'(out_wr_addr), 64'd3);
        chk("single_data", out_wr_data, 64'h3FF0_0000_0000_0000);
        tick();
        chk("single_drained", 64'(out_wr_en), 64'd0);
        chk("single_cnt", 64'(out_commit_cnt), 64'd1);
        chk("single_sticky", 64'({out_sticky_OF, out_sticky_UF}), 64'd0);

        // Backpressure
        in_wr_ready = 1'b0;
        in_valid = 1'b1; in_result = 64'h1111; in_rd = 5'd5;
        tick();
        in_result = 64'h2222; in_rd = 5'd6;
        tick();
        chk("bp_full_ready", 64'(out_ready), 64'd0);
        chk("bp_head_addr", 64'(out_wr_addr), 64'd5);
        in_result = 64'h3333; in_rd = 5'd7;
        tick();
        in_valid = 1'b0;
        chk("bp_hold_addr", 64'(out_wr_addr), 64'd5);
        chk("bp_hold_data", out_wr_data, 64'h1111);
        in_wr_ready = 1'b1;
        #1;
        chk("bp_no_bypass", 64'(out_ready), 64'd0);
        tick();
        chk("bp_second_addr", 64'(out_wr_addr), 64'd6);
        chk("bp_second_data", out_wr_data, 64'h2222);
        chk("bp_cnt_a", 64'(out_commit_cnt), 64'd2);
        chk("bp_ready_again", 64'(out_ready), 64'd1);
        tick();
        chk("bp_drained", 64'(out_wr_en), 64'd0);
        chk("bp_cnt_b", 64'(out_commit_cnt), 64'd3);

        // Flags and interrupt
        in_irq_en = 1'b1;
        in_valid = 1'b1; in_result = 64'h7FF0_0000_0000_0000; in_rd = 5'd1; in_flag_OF = 1'b1;
        tick();
        in_valid = 1'b0; in_flag_OF = 1'b0;
        chk("of_no_flag_on_push", 64'(out_sticky_OF), 64'd0);
        chk("of_no_irq_on_push", 64'(out_irq), 64'd0);
        tick();
        chk("of_irq_pulse", 64'(out_irq), 64'd1);
        chk("of_sticky", 64'(out_sticky_OF), 64'd1);
        chk("of_cnt", 64'(out_commit_cnt), 64'd4);
        tick();
        chk("of_irq_single", 64'(out_irq), 64'd0);
        chk("of_sticky_kept", 64'(out_sticky_OF), 64'd1);
        in_valid = 1'b1; in_result = 64'h0000_0000_0000_0001; in_rd = 5'd2; in_flag_UF = 1'b1;
        tick();
        in_valid = 1'b0; in_flag_UF = 1'b0; in_flag_clr = 1'b1;
        tick();
        in_flag_clr = 1'b0;
        chk("clr_commit_of", 64'(out_sticky_OF), 64'd0);
        chk("clr_commit_uf", 64'(out_sticky_UF), 64'd1);
        chk("uf_no_irq", 64'(out_irq), 64'd0);
        chk("uf_cnt", 64'(out_commit_cnt), 64'd5);
        in_irq_en = 1'b0;
        in_valid = 1'b1; in_result = 64'hFFF0_0000_0000_0000; in_rd = 5'd4; in_flag_OF = 1'b1;
        tick();
        in_valid = 1'b0; in_flag_OF = 1'b0;
        tick();
        chk("irq_masked", 64'(out_irq), 64'd0);
        chk("masked_sticky", 64'(out_sticky_OF), 64'd1);
        chk("masked_cnt", 64'(out_commit_cnt), 64'd6);
        in_flag_clr = 1'b1;
        tick();
        in_flag_clr = 1'b0;
        chk("clr_only", 64'({out_sticky_OF, out_sticky_UF}), 64'd0);

        // Streaming
        n_wr = 0; ready_drop = 1'b0;
        in_wr_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_result = 64'hC000_0000_0000_0000 | 64'(i * 7 + 1);
            in_rd = 5'(i);
            observe();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) observe();
        chk("stream_writes", 64'(n_wr), 64'd100);
        chk("stream_never_full", 64'(ready_drop), 64'd0);
        chk("stream_model_empty", 64'(q_data.size()), 64'd0);
        chk("stream_cnt", 64'(out_commit_cnt), 64'd106);

        // Counter wrap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wrap_cnt_reset", 64'(out_commit_cnt), 64'd0);
        in_valid = 1'b1; in_rd = 5'd10; in_result = 64'h4000_0000_0000_0000;
        for (int i = 0; i < 65535; i++) tick();
        in_valid = 1'b0;
        tick();
        chk("wrap_cnt_max", 64'(out_commit_cnt), 64'hFFFF);
        chk("wrap_drained", 64'(out_wr_en), 64'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("wrap_cnt_zero", 64'(out_commit_cnt), 64'd0);

        // Reset with two buffered entries
        in_wr_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("rstbuf_full", 64'(out_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rstbuf_no_write", 64'(out_wr_en), 64'd0);
            tick();
        end
        chk("rstbuf_cnt", 64'(out_commit_cnt), 64'd0);
        chk("rstbuf_ready", 64'(out_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
